posoco_scroller: RTL and testbench

POSOCO_SCROLLER -- requirements
Module: posoco_scroller

---
 rtl/posoco_scroller.sv | 128 ++++++++++++
 tb/tb_posoco_scroller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/posoco_scroller.sv
// Scrolling message source: a 64x8 segment RAM read through a rotating offset.
// Optional reverse scrolling (input dir) is enabled by defining POSOCO_SCROLL_REVERSE_EN.
//
// state | meaning
// IDLE  | scrolling halted, offset and len held, reads still serviced
// RUN   | divider counting, offset advances once per TICK_DIV cycles
module posoco_scroller #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [6:0] msg_len,
  input  logic       start,
  input  logic       stop,
`ifdef POSOCO_SCROLL_REVERSE_EN
  input  logic       dir,
`endif
  input  logic       rd_req,
  input  logic [3:0] rd_digit,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       running,
  output logic       wrap
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int DIV_W = 24;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [7:0]       mem [64];
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       offset;
  logic [6:0]       len;

  logic       start_ok;
  logic       tick;
  logic [6:0] rd_sum;
  logic [5:0] rd_idx;
  logic [5:0] offset_next;
  logic       wrap_next;

  assign start_ok = start && (msg_len >= 7'd10) && (msg_len <= 7'd64);
  assign tick     = (state == RUN) && (div_cnt == DIV_LAST);
  assign running  = (state == RUN);

  // offset < len and digit <= 9 < len, so one conditional subtract brings s into 0..len-1
  always_comb begin
    rd_sum = {1'b0, offset} + {3'b000, rd_digit};
    rd_idx = 6'(rd_sum - ((rd_sum >= len) ? len : 7'd0));
  end

  always_comb begin
    offset_next = offset + 6'd1;
    wrap_next   = 1'b0;
`ifdef POSOCO_SCROLL_REVERSE_EN
    if (dir) begin
      if (offset == 6'd0) begin
        offset_next = 6'(len - 7'd1);
        wrap_next   = 1'b1;
      end else begin
        offset_next = offset - 6'd1;
      end
    end else if ({1'b0, offset} == len - 7'd1) begin
      offset_next = 6'd0;
      wrap_next   = 1'b1;
    end
`else
    if ({1'b0, offset} == len - 7'd1) begin
      offset_next = 6'd0;
      wrap_next   = 1'b1;
    end
`endif
  end

  // RAM contents survive reset; reset only blocks a same-cycle write
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= (rd_digit > 4'd9) ? 8'h00 : mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      offset  <= 6'd0;
      len     <= 7'd10;
      div_cnt <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        div_cnt <= '0;
      end else if (start_ok) begin
        state   <= RUN;
        len     <= msg_len;
        offset  <= 6'd0;
        div_cnt <= '0;
      end else if (state == RUN) begin
        if (tick) begin
          div_cnt <= '0;
          offset  <= offset_next;
          wrap    <= wrap_next;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_posoco_scroller.sv
// Directed bench for posoco_scroller at TICK_DIV=4; offset is observed through digit reads with RAM[i]=i.
// Reverse-scroll vectors run only when POSOCO_SCROLL_REVERSE_EN is defined.
module tb_posoco_scroller;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] msg_len;
  logic       start;
  logic       stop;
  logic       dir;
  logic       rd_req;
  logic [3:0] rd_digit;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       running;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  posoco_scroller #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .msg_len  (msg_len),
    .start    (start),
    .stop     (stop),
`ifdef POSOCO_SCROLL_REVERSE_EN
    .dir      (dir),
`endif
    .rd_req   (rd_req),
    .rd_digit (rd_digit),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .running  (running),
    .wrap     (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock edge; inputs change and outputs are sampled 1ns after it
  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_digit(input logic [3:0] d, input logic [7:0] exp, input string tag);
    rd_req   = 1'b1;
    rd_digit = d;
    do_cycle();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_start(input logic [6:0] len_v);
    msg_len = len_v;
    start   = 1'b1;
    do_cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    do_cycle();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = 7'd0;
    start = 1'b0; stop = 1'b0; dir = 1'b0; rd_req = 1'b0; rd_digit = '0;
    do_cycle();
    do_cycle();
    check("rst_running", 32'(running), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = 8'(i);
      do_cycle();
    end
    wr_en = 1'b0;

    // start with len 12, halt at offset 0, read the visible window
    pulse_start(7'd12);
    check("start_running", 32'(running), 32'd1);
    pulse_stop();
    check("stop_running", 32'(running), 32'd0);
    for (int d = 0; d < 10; d++) begin
      read_digit(4'(d), 8'(d), $sformatf("win_d%0d", d));
    end
    do_cycle();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);
    check("idle_rd_hold", 32'(rd_data), 32'd9);

    // 11 ticks reach offset 11; the 12th wraps to 0
    pulse_start(7'd12);
    repeat (44) do_cycle();
    read_digit(4'd2, 8'd1, "off11_d2");
    read_digit(4'd0, 8'd11, "off11_d0");
    do_cycle();
    check("pre_wrap", 32'(wrap), 32'd0);
    do_cycle();
    check("wrap_pulse", 32'(wrap), 32'd1);
    read_digit(4'd0, 8'd0, "post_wrap_d0");
    check("wrap_one_cycle", 32'(wrap), 32'd0);

    // out-of-range lengths are ignored; 10 and 64 are accepted
    pulse_stop();
    pulse_start(7'd9);
    check("len9_ignored", 32'(running), 32'd0);
    pulse_start(7'd65);
    check("len65_ignored", 32'(running), 32'd0);
    read_digit(4'd5, 8'd5, "ignored_d5");
    read_digit(4'd12, 8'h00, "digit12");
    pulse_start(7'd10);
    check("len10_accepted", 32'(running), 32'd1);
    pulse_stop();
    pulse_start(7'd64);
    check("len64_accepted", 32'(running), 32'd1);

    // stop beats a simultaneous start
    msg_len = 7'd12; start = 1'b1; stop = 1'b1;
    do_cycle();
    start = 1'b0; stop = 1'b0;
    check("start_stop_same", 32'(running), 32'd0);

    // stop at offset 5 holds offset and len
    pulse_start(7'd12);
    repeat (20) do_cycle();
    pulse_stop();
    check("midrun_stop", 32'(running), 32'd0);
    repeat (20) do_cycle();
    read_digit(4'd0, 8'd5, "held_d0");
    read_digit(4'd9, 8'd2, "held_d9");

    // read-during-write returns the old data
    pulse_start(7'd12);
    pulse_stop();
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hAA;
    read_digit(4'd3, 8'd3, "rdw_old");
    wr_en = 1'b0;
    read_digit(4'd3, 8'hAA, "rdw_new");

    // reset mid-run at offset 7 overrides start, write and read
    pulse_start(7'd12);
    repeat (28) do_cycle();
    read_digit(4'd0, 8'd7, "off7_d0");
    rst = 1'b1; start = 1'b1; msg_len = 7'd12; rd_req = 1'b1; rd_digit = 4'd0;
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h55;
    do_cycle();
    rst = 1'b0; start = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'h00);
    read_digit(4'd7, 8'd7, "ram7_kept");

`ifdef POSOCO_SCROLL_REVERSE_EN
    dir = 1'b1;
    pulse_start(7'd12);
    repeat (3) do_cycle();
    check("rev_pre_wrap", 32'(wrap), 32'd0);
    do_cycle();
    check("rev_wrap", 32'(wrap), 32'd1);
    read_digit(4'd0, 8'd11, "rev_off11_d0");
    check("rev_wrap_one_cycle", 32'(wrap), 32'd0);
    dir = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
